// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SCLK-domain SPI frame receiver with toggle-handshake publish
module spi_frame_rx #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int FRAME_N = 16
) (
    input  logic              SCLK_sig,
    input  logic              nrst,
    input  logic              cs_n_sync,
    input  logic              MOSI_sig,
    input  logic              ack_tgl,
    output logic              frame_tgl,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic [7:0]        frame_cnt,
    output logic              err_abort,
    output logic              err_long,
    output logic              err_drop
);
    localparam int CNT_W = $clog2(FRAME_N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_N - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_N);

    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_N-2:0] shift_q, shift_d;
    logic               long_q, long_d;
    logic [FRAME_N-1:0] full_word;

    logic              tgl_q, tgl_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              abort_q;
    logic              elong_q, elong_d;
    logic              drop_q, drop_d;

    assign full_word = {shift_q, MOSI_sig};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        long_d    = long_q;
        if (bit_cnt_q != FULL && !long_q) begin
            shift_d   = full_word[FRAME_N-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
            long_d = 1'b1;
        end
    end

    // Window state is held clear asynchronously for as long as chip select is high.
    always_ff @(posedge SCLK_sig or negedge nrst or posedge cs_n_sync) begin
        if (!nrst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            long_q    <= 1'b0;
        end else if (cs_n_sync) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            long_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            long_q    <= long_d;
        end
    end

    // Sampled on the CS rising edge, so bit_cnt_q still holds its pre-clear value.
    always_ff @(posedge cs_n_sync or negedge nrst) begin
        if (!nrst) begin
            abort_q <= 1'b0;
        end else if (bit_cnt_q != '0 && bit_cnt_q != FULL) begin
            abort_q <= 1'b1;
        end
    end

    always_comb begin
        tgl_d   = tgl_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        elong_d = elong_q;
        drop_d  = drop_q;
        if (bit_cnt_q == LAST) begin
            if (tgl_q == ack_tgl) begin
                rw_d   = full_word[FRAME_N-1];
                addr_d = full_word[FRAME_N-2 -: ADDR_W];
                data_d = full_word[DATA_W-1:0];
                tgl_d  = ~tgl_q;
                cnt_d  = cnt_q + 8'd1;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (bit_cnt_q == FULL) begin
            elong_d = 1'b1;
        end
    end

    always_ff @(posedge SCLK_sig or negedge nrst) begin
        if (!nrst) begin
            tgl_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= 8'd0;
            elong_q <= 1'b0;
            drop_q  <= 1'b0;
        end else if (!cs_n_sync) begin
            tgl_q   <= tgl_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            elong_q <= elong_d;
            drop_q  <= drop_d;
        end
    end

    assign frame_tgl  = tgl_q;
    assign frame_rw   = rw_q;
    assign frame_addr = addr_q;
    assign frame_data = data_q;
    assign frame_cnt  = cnt_q;
    assign err_abort  = abort_q;
    assign err_long   = elong_q;
    assign err_drop   = drop_q;
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed self-checking bench for spi_frame_rx
module tb_spi_frame_rx;
    logic       SCLK_sig = 1'b0;
    logic       nrst;
    logic       cs_n_sync;
    logic       MOSI_sig;
    logic       ack_tgl;
    logic       frame_tgl;
    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic [7:0] frame_cnt;
    logic       err_abort;
    logic       err_long;
    logic       err_drop;

    int errors = 0;
    int checks = 0;

    spi_frame_rx #(.ADDR_W(7), .DATA_W(8), .FRAME_N(16)) dut (
        .SCLK_sig  (SCLK_sig),
        .nrst      (nrst),
        .cs_n_sync (cs_n_sync),
        .MOSI_sig  (MOSI_sig),
        .ack_tgl   (ack_tgl),
        .frame_tgl (frame_tgl),
        .frame_rw  (frame_rw),
        .frame_addr(frame_addr),
        .frame_data(frame_data),
        .frame_cnt (frame_cnt),
        .err_abort (err_abort),
        .err_long  (err_long),
        .err_drop  (err_drop)
    );

    always #5 SCLK_sig = ~SCLK_sig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input int n);
        @(negedge SCLK_sig);
        cs_n_sync = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            MOSI_sig = w[i];
            @(negedge SCLK_sig);
        end
    endtask

    task automatic cs_off();
        cs_n_sync = 1'b1;
        MOSI_sig  = 1'b0;
        @(negedge SCLK_sig);
    endtask

    task automatic pulse_reset();
        nrst    = 1'b0;
        ack_tgl = 1'b0;
        #2;
        cs_n_sync = 1'b1;
        nrst      = 1'b1;
    endtask

    task automatic chk_frame(input string tag, input logic tgl, input logic rw,
                             input logic [6:0] addr, input logic [7:0] data, input logic [7:0] cnt);
        chk({tag, "_tgl"},  {31'd0, frame_tgl}, {31'd0, tgl});
        chk({tag, "_rw"},   {31'd0, frame_rw},  {31'd0, rw});
        chk({tag, "_addr"}, {25'd0, frame_addr}, {25'd0, addr});
        chk({tag, "_data"}, {24'd0, frame_data}, {24'd0, data});
        chk({tag, "_cnt"},  {24'd0, frame_cnt},  {24'd0, cnt});
    endtask

    task automatic chk_err(input string tag, input logic ab, input logic lg, input logic dr);
        chk({tag, "_err_abort"}, {31'd0, err_abort}, {31'd0, ab});
        chk({tag, "_err_long"},  {31'd0, err_long},  {31'd0, lg});
        chk({tag, "_err_drop"},  {31'd0, err_drop},  {31'd0, dr});
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b0; cs_n_sync = 1'b1; MOSI_sig = 1'b0; ack_tgl = 1'b0;
        repeat (2) @(negedge SCLK_sig);
        nrst = 1'b1;
        @(negedge SCLK_sig);
        chk_frame("reset", 1'b0, 1'b0, 7'h00, 8'h00, 8'd0);
        chk_err("reset", 1'b0, 1'b0, 1'b0);

        // 1: single write frame, consumer idle
        send(32'h82A5, 16);
        chk_frame("t1", 1'b1, 1'b1, 7'h02, 8'hA5, 8'd1);
        cs_off();
        chk_err("t1", 1'b0, 1'b0, 1'b0);

        // 2: second frame without ack is dropped
        send(32'h1234, 16);
        cs_off();
        chk_frame("t2", 1'b1, 1'b1, 7'h02, 8'hA5, 8'd1);
        chk_err("t2", 1'b0, 1'b0, 1'b1);
        ack_tgl = 1'b1;

        // 3: abort after 9 bits, then a good frame
        send(32'h843C >> 7, 9);
        cs_off();
        chk("t3_abort", {31'd0, err_abort}, 32'd1);
        chk("t3_cnt_hold", {24'd0, frame_cnt}, 32'd1);
        send(32'h843C, 16);
        cs_off();
        chk_frame("t3", 1'b0, 1'b1, 7'h04, 8'h3C, 8'd2);
        ack_tgl = 1'b0;

        // 4: overlong window of 20 edges from a fresh reset
        pulse_reset();
        send({16'h0155, 4'hF}, 20);
        cs_off();
        chk_frame("t4", 1'b1, 1'b0, 7'h01, 8'h55, 8'd1);
        chk_err("t4", 1'b0, 1'b1, 1'b0);
        ack_tgl = 1'b1;

        // 5: reset mid-frame, then a normal frame
        send(32'h10, 5);
        nrst    = 1'b0;
        ack_tgl = 1'b0;
        #2;
        chk_frame("t5_rst", 1'b0, 1'b0, 7'h00, 8'h00, 8'd0);
        chk_err("t5_rst", 1'b0, 1'b0, 1'b0);
        cs_n_sync = 1'b1;
        nrst      = 1'b1;
        @(negedge SCLK_sig);
        chk("t5_no_abort", {31'd0, err_abort}, 32'd0);
        send(32'h81FF, 16);
        cs_off();
        chk_frame("t5", 1'b1, 1'b1, 7'h01, 8'hFF, 8'd1);
        ack_tgl = 1'b1;

        // 6: 256 acked frames wrap the counter
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            send({16'h9000 | 16'(i)}, 16);
            cs_off();
            ack_tgl = ~ack_tgl;
            if (i == 254) chk("t6_cnt255", {24'd0, frame_cnt}, 32'd255);
        end
        chk_frame("t6", 1'b0, 1'b1, 7'h10, 8'hFF, 8'd0);
        chk_err("t6", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
